// File: rtl/hack_boot_ctrl.sv
// Boot loader controller for a Hack CPU: streams program words into instruction ROM,
// holds the CPU in reset while loading, then releases it after a short settle window.
module hack_boot_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_reset,
  output logic [15:0] words_loaded,
  output logic        load_err
);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

  state_t      state;
  logic [14:0] ptr;
  logic [15:0] cnt;
  logic        hold_cnt;

  // Both decoded purely from the state register, so no input reaches them combinationally.
  assign in_ready  = (state == LOAD);
  assign cpu_reset = (state != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_wdata    <= '0;
      words_loaded <= '0;
      load_err     <= 1'b0;
      ptr          <= '0;
      cnt          <= '0;
      hold_cnt     <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            ptr   <= '0;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            rom_we    <= 1'b1;
            rom_addr  <= ptr;
            rom_wdata <= in_data;
            ptr       <= ptr + 15'd1;
            cnt       <= cnt + 16'd1;
            if (in_last) begin
              state        <= HOLD;
              hold_cnt     <= 1'b0;
              words_loaded <= cnt + 16'd1;
            end else if (ptr == 15'h7FFF) begin
              // ROM is full and the stream did not end: the last word is still written.
              state        <= ERR;
              load_err     <= 1'b1;
              words_loaded <= cnt + 16'd1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt) state <= RUN;
          else          hold_cnt <= 1'b1;
        end
        RUN, ERR: begin
          if (load_start) begin
            state    <= LOAD;
            ptr      <= '0;
            cnt      <= '0;
            load_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Directed bench for hack_boot_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_hack_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset, load_start, in_valid, in_last;
  logic [15:0] in_data;
  logic        in_ready, rom_we, cpu_reset, load_err;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata, words_loaded;

  int tests = 0;
  int fails = 0;

  logic [14:0] log_addr[$];
  logic [15:0] log_data[$];

  hack_boot_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .rom_we(rom_we),
    .rom_addr(rom_addr), .rom_wdata(rom_wdata), .cpu_reset(cpu_reset),
    .words_loaded(words_loaded), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, landing on the next falling edge; record any ROM write seen there.
  task automatic step();
    @(negedge clk);
    if (rom_we === 1'b1) begin
      log_addr.push_back(rom_addr);
      log_data.push_back(rom_wdata);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    int bad;
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #2;
    check("reset_outputs", {cpu_reset, in_ready, rom_we, load_err, words_loaded},
          {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    step(); step();
    reset = 1'b0;
    clear_log();

    // Idle with stray loader traffic: nothing may be accepted.
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle", {cpu_reset, in_ready, rom_we, words_loaded}, {1'b1, 1'b0, 1'b0, 16'h0});
    end
    in_valid = 1'b0; in_last = 1'b0;

    // Three-word program, back to back.
    load_start = 1'b1; step(); load_start = 1'b0;
    check("load_entry", {in_ready, cpu_reset, rom_we}, {1'b1, 1'b1, 1'b0});
    in_valid = 1'b1; in_data = 16'h000F; step();
    check("wr0", {rom_we, 1'b0, rom_addr, rom_wdata}, {1'b1, 1'b0, 15'd0, 16'h000F});
    in_data = 16'hEC10; step();
    check("wr1", {rom_we, 1'b0, rom_addr, rom_wdata}, {1'b1, 1'b0, 15'd1, 16'hEC10});
    in_data = 16'h0014; in_last = 1'b1; step();
    check("wr2", {rom_we, 1'b0, rom_addr, rom_wdata}, {1'b1, 1'b0, 15'd2, 16'h0014});
    check("hold1", {in_ready, cpu_reset, words_loaded}, {1'b0, 1'b1, 16'd3});
    load_start = 1'b1; in_last = 1'b1; step();
    load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("hold2", {cpu_reset, rom_we, in_ready}, {1'b1, 1'b0, 1'b0});
    step();
    check("run_after_3", {cpu_reset, in_ready, words_loaded}, {1'b0, 1'b0, 16'd3});
    check("log_3", log_addr.size(), 3);

    // RUN must not accept data.
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'hBEEF; step();
    check("run_no_accept", {rom_we, cpu_reset, in_ready}, {1'b0, 1'b0, 1'b0});
    in_valid = 1'b0; in_last = 1'b0;

    // Four words with in_valid toggling; in_last floats high on idle cycles.
    load_start = 1'b1; step(); load_start = 1'b0;
    check("reload_edge", {cpu_reset, in_ready}, {1'b1, 1'b1});
    clear_log();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      in_last  = (i == 6) || (i % 2 == 1);
      in_data  = 16'h1000 + 16'(i / 2);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    step();
    check("toggle_run", {cpu_reset, words_loaded}, {1'b0, 16'd4});
    check("toggle_count", log_addr.size(), 4);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_addr[i] !== 15'(i) || log_data[i] !== 16'h1000 + 16'(i)) bad++;
    check("toggle_contents", bad, 0);

    // Single-word reload from RUN.
    clear_log();
    load_start = 1'b1; step(); load_start = 1'b0;
    check("single_reload_edge", cpu_reset, 1'b1);
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'hE308; step();
    in_valid = 1'b0; in_last = 1'b0;
    check("single_wr", {rom_we, 1'b0, rom_addr, rom_wdata}, {1'b1, 1'b0, 15'd0, 16'hE308});
    step();
    check("single_hold", cpu_reset, 1'b1);
    step();
    check("single_run", {cpu_reset, words_loaded, 8'(log_addr.size())}, {1'b0, 16'd1, 8'd1});

    // Overflow: 32768 words with no end marker.
    load_start = 1'b1; step(); load_start = 1'b0;
    clear_log();
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      in_data = 16'(i) ^ 16'h5A5A;
      step();
    end
    check("ovf_last_wr", {rom_we, 1'b0, rom_addr, rom_wdata},
          {1'b1, 1'b0, 15'h7FFF, 16'h7FFF ^ 16'h5A5A});
    check("ovf_flags", {load_err, in_ready, cpu_reset, words_loaded},
          {1'b1, 1'b0, 1'b1, 16'h8000});
    check("ovf_count", log_addr.size(), 32768);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_addr[i] !== 15'(i)) bad++;
    check("ovf_addrs", bad, 0);
    step();
    check("err_no_accept", {rom_we, load_err, in_ready}, {1'b0, 1'b1, 1'b0});
    in_valid = 1'b0;
    load_start = 1'b1; step(); load_start = 1'b0;
    check("err_clear", {load_err, in_ready, cpu_reset}, {1'b0, 1'b1, 1'b1});

    // Reset mid-load after two words, while the second write is on the bus.
    in_valid = 1'b1; in_data = 16'h1111; step();
    in_data = 16'h2222; step();
    check("pre_reset_wr", {rom_we, 1'b0, rom_addr, rom_wdata}, {1'b1, 1'b0, 15'd1, 16'h2222});
    clear_log();
    reset = 1'b1; #1;
    check("async_reset", {cpu_reset, in_ready, rom_we, load_err, rom_addr, rom_wdata, words_loaded},
          {1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 16'd0, 16'd0});
    in_data = 16'h3333; step(); step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("post_reset_idle", {in_ready, cpu_reset, rom_we}, {1'b0, 1'b1, 1'b0});
    check("post_reset_no_writes", log_addr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hack_boot_ctrl.md
HACK_BOOT_CTRL -- requirements
Module: hack_boot_ctrl

Interface
REQ-001 SHALL provide port: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL provide port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL provide port: load_start  in  1  request to (re)load program and hold CPU.
REQ-004 SHALL provide port: in_valid  in  1  loader word present.
REQ-005 SHALL provide port: in_data  in  16  instruction word to store.
REQ-006 SHALL provide port: in_last  in  1  qualifies in_data as final program word.
REQ-007 SHALL provide port: in_ready  out  1  controller accepts a word this cycle.
REQ-008 SHALL provide port: rom_we  out  1  instruction-ROM write strobe.
REQ-009 SHALL provide port: rom_addr  out  15  instruction-ROM write address.
REQ-010 SHALL provide port: rom_wdata  out  16  instruction-ROM write data.
REQ-011 SHALL provide port: cpu_reset  out  1  drives CPU reset; 1 = CPU held, pc forced to 0.
REQ-012 SHALL provide port: words_loaded  out  16  word count of most recent load.
REQ-013 SHALL provide port: load_err  out  1  program exceeded 32768 words.

Function
REQ-014 SHALL implement states IDLE, LOAD, HOLD, RUN, ERR.
REQ-015 SHALL make in_ready=1 only in LOAD and cpu_reset=0 only in RUN, both decoded from registered state (no input-to-output combinational path).
REQ-016 SHALL transition IDLE->LOAD on load_start=1; on entry, write pointer=0 and word counter=0.
REQ-017 SHALL accept a word on a rising edge where state=LOAD and in_valid=1.
REQ-018 SHALL, in the cycle after acceptance, present rom_we=1, rom_addr=pointer at acceptance, rom_wdata=accepted in_data (1-cycle write latency); rom_we=0 in every other cycle.
REQ-019 SHALL increment pointer and counter by 1 per accepted word; back-to-back acceptance every cycle supported.
REQ-020 SHALL transition LOAD->HOLD on accepting a word with in_last=1; that word is written normally.
REQ-021 SHALL remain in HOLD exactly 2 cycles, then enter RUN; cpu_reset falls on the 2nd edge after the last-word edge.
REQ-022 SHALL update words_loaded to the counter value on the LOAD->HOLD transition and hold it otherwise.
REQ-023 SHALL, on accepting a word at pointer 32767 with in_last=0, write it and enter ERR; load_err=1, in_ready=0, cpu_reset=1; words_loaded set to 32768.
REQ-024 SHALL transition RUN->LOAD and ERR->LOAD on load_start=1; load_err cleared on that edge; cpu_reset rises on that edge.
REQ-025 SHALL ignore load_start in LOAD and HOLD.
REQ-026 SHALL not accept data in IDLE, HOLD, RUN, ERR regardless of in_valid/in_last.
REQ-027 SHALL ignore in_last when in_valid=0.

Reset
REQ-028 SHALL on reset=1 immediately force: state IDLE, cpu_reset=1, in_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, words_loaded=0, load_err=0, pointer=0, counter=0.
REQ-029 SHALL abort any load on reset mid-LOAD/HOLD; a pending write (REQ-018) is cancelled, rom_we=0 immediately.
REQ-030 SHALL resume only via load_start after reset deasserts.

Verification
REQ-031 SHALL verify: reset pulse, then idle 5 cycles -> cpu_reset=1, in_ready=0, rom_we=0, words_loaded=0 throughout.
REQ-032 SHALL verify: load_start, then words 0x000F, 0xEC10, 0x0014 (last on 3rd) every cycle -> writes (0,0x000F),(1,0xEC10),(2,0x0014); cpu_reset=0 two edges after 3rd acceptance; words_loaded=3.
REQ-033 SHALL verify: in_valid toggling 1/0 during load of 4 words -> exactly 4 writes at addresses 0..3, no duplicates, words_loaded=4.
REQ-034 SHALL verify: in RUN, load_start plus single word 0xE308 with last -> cpu_reset=1 next edge, write (0,0xE308), words_loaded=1, RUN again after HOLD.
REQ-035 SHALL verify: 32768 words with in_last=0 -> last write at 0x7FFF, load_err=1, in_ready=0, cpu_reset=1; load_start clears load_err.
REQ-036 SHALL verify: reset asserted mid-load after 2 words -> all outputs at REQ-028 values immediately, no further writes.
